// File: rtl/hog_wr_pkg.sv
// Shared FSM encoding and AXI encodings for the HOG feature AXI writer.
package hog_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_RUN,
        ST_WAIT_B,
        ST_DONE
    } wr_state_t;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BYTES_PER_BEAT = 64;

endpackage

// File: rtl/hog_feature_axi_writer_if.sv
// AXI4 write-only channel bundle (AW/W/B) between the feature writer and DDR.
interface hog_feature_axi_writer_if #(
    parameter int AXI_DW = 512,
    parameter int AXI_AW = 32
);
    logic [AXI_AW-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/hog_wr_aw_gen.sv
// Purpose: issues one INCR AW per burst, keeping at most MAX_OUTST bursts ahead of W.
// Latency: awvalid rises one cycle after an issue slot opens; addresses step by one burst.
// Backpressure: awvalid/awaddr held stable until awready; go low clears all state.
module hog_wr_aw_gen
    import hog_wr_pkg::*;
#(
    parameter int AXI_AW     = 32,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BURSTS = 124,
    parameter int MAX_OUTST  = 2
) (
    input  logic              aclk,
    input  logic              arest,
    input  logic [AXI_AW-1:0] base,
    input  logic              go,
    input  logic              w_burst_done,
    input  logic              awready,
    output logic [AXI_AW-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    output logic              aw_avail
);
    localparam int IDX_W       = $clog2(NUM_BURSTS + 1);
    localparam int OUT_W       = $clog2(MAX_OUTST + 1);
    localparam int BURST_SHIFT = $clog2(BURST_LEN * BYTES_PER_BEAT);

    logic [IDX_W-1:0] burst_idx;
    logic [OUT_W-1:0] outst;
    logic             aw_hs;
    logic             can_issue;

    assign aw_hs     = awvalid && awready;
    assign can_issue = go && !awvalid
                       && (burst_idx < IDX_W'(NUM_BURSTS))
                       && (outst < OUT_W'(MAX_OUTST));

    // Fixed fields are only driven while a request is presented so the bus idles at zero.
    assign awlen    = awvalid ? 8'(BURST_LEN - 1) : 8'd0;
    assign awsize   = awvalid ? AXI_SIZE_64B : 3'b000;
    assign awburst  = awvalid ? AXI_BURST_INCR : 2'b00;
    assign aw_avail = (outst != '0);

    always_ff @(posedge aclk) begin
        if (arest || !go) begin
            burst_idx <= '0;
            outst     <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
        end else begin
            if (aw_hs) begin
                awvalid   <= 1'b0;
                burst_idx <= burst_idx + 1'b1;
            end else if (can_issue) begin
                awvalid <= 1'b1;
                awaddr  <= base + (AXI_AW'(burst_idx) << BURST_SHIFT);
            end
            // Outstanding = AWs accepted minus W bursts fully sent.
            case ({aw_hs, w_burst_done})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/hog_feature_axi_writer.sv
// Purpose: kicks the feature reader, buffers one word, writes a frame to DDR as INCR bursts (WR_PERF_CNT_EN adds perf_cycles).
// Latency: res_data_valid at cycle N gives wvalid at N+1 once the burst's AW is accepted.
// Backpressure: single-entry buffer; a word arriving while full without a W handshake is dropped and sets err.
module hog_feature_axi_writer
    import hog_wr_pkg::*;
#(
    parameter int AXI_DW      = 512,
    parameter int AXI_AW      = 32,
    parameter int BURST_LEN   = 16,
    parameter int TOTAL_BEATS = 1984,
    parameter int MAX_OUTST   = 2
) (
    input  logic              aclk,
    input  logic              arest,
    input  logic              start,
    input  logic [AXI_AW-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              res_start,
    output logic              w_handshake,
    output logic              wr_done,
    input  logic [AXI_DW-1:0] res_data,
    input  logic              res_data_valid,
`ifdef WR_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    hog_feature_axi_writer_if.master m_axi
);
    localparam int NUM_BURSTS = TOTAL_BEATS / BURST_LEN;
    localparam int BEAT_W     = $clog2(TOTAL_BEATS + 1);
    localparam int BIB_W      = $clog2(BURST_LEN);
    localparam int BCNT_W     = $clog2(NUM_BURSTS + 1);
    localparam logic [AXI_AW-1:0] ADDR_MASK = ~AXI_AW'(1023);

    wr_state_t         state, state_nxt;
    logic [AXI_AW-1:0] base_q;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BIB_W-1:0]  beat_in_burst;
    logic [BCNT_W-1:0] b_cnt;
    logic [AXI_DW-1:0] buf_data;
    logic              buf_full;
    logic              aw_avail, w_hs, b_hs, accept, frame_start, active;
    logic              last_beat, w_burst_done, overflow, bad_resp;

    assign frame_start  = (state == ST_IDLE) && start;
    assign active       = (state == ST_RUN) || (state == ST_WAIT_B);
    assign accept       = (state == ST_KICK) || (state == ST_RUN);

    assign m_axi.wvalid = buf_full && aw_avail;
    assign m_axi.wdata  = buf_data;
    assign m_axi.wstrb  = m_axi.wvalid ? '1 : '0;
    assign m_axi.wlast  = (beat_in_burst == BIB_W'(BURST_LEN - 1));
    assign m_axi.bready = active;

    assign w_hs         = m_axi.wvalid && m_axi.wready;
    assign b_hs         = m_axi.bvalid && m_axi.bready;
    assign w_handshake  = w_hs;
    assign w_burst_done = w_hs && m_axi.wlast;
    assign last_beat    = w_hs && (beat_cnt == BEAT_W'(TOTAL_BEATS - 1));
    assign overflow     = accept && res_data_valid && buf_full && !w_hs;
    assign bad_resp     = b_hs && (m_axi.bresp != AXI_RESP_OKAY);

    always_ff @(posedge aclk) begin
        if (arest) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        res_start = 1'b0;
        done      = 1'b0;
        wr_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_KICK;
            end
            ST_KICK: begin
                res_start = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN:    if (last_beat) state_nxt = ST_WAIT_B;
            ST_WAIT_B: if (b_cnt == BCNT_W'(NUM_BURSTS)) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                wr_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arest) begin
            base_q        <= '0;
            beat_cnt      <= '0;
            beat_in_burst <= '0;
            b_cnt         <= '0;
        end else if (frame_start) begin
            base_q        <= base_addr & ADDR_MASK;
            beat_cnt      <= '0;
            beat_in_burst <= '0;
            b_cnt         <= '0;
        end else begin
            if (w_hs) begin
                beat_cnt      <= beat_cnt + 1'b1;
                beat_in_burst <= m_axi.wlast ? '0 : beat_in_burst + 1'b1;
            end
            if (b_hs) b_cnt <= b_cnt + 1'b1;
        end
    end

    // A word may land in the same cycle the held word drains; only a true collision drops.
    always_ff @(posedge aclk) begin
        if (arest || frame_start) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (accept && res_data_valid && (!buf_full || w_hs)) begin
            buf_full <= 1'b1;
            buf_data <= res_data;
        end else if (w_hs) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (arest || frame_start)     err <= 1'b0;
        else if (overflow || bad_resp) err <= 1'b1;
    end

    hog_wr_aw_gen #(
        .AXI_AW     (AXI_AW),
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .MAX_OUTST  (MAX_OUTST)
    ) u_aw_gen (
        .aclk         (aclk),
        .arest        (arest),
        .base         (base_q),
        .go           (active),
        .w_burst_done (w_burst_done),
        .awready      (m_axi.awready),
        .awaddr       (m_axi.awaddr),
        .awlen        (m_axi.awlen),
        .awsize       (m_axi.awsize),
        .awburst      (m_axi.awburst),
        .awvalid      (m_axi.awvalid),
        .aw_avail     (aw_avail)
    );

`ifdef WR_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge aclk) begin
        if (arest || frame_start) perf_q <= '0;
        else if (state != ST_IDLE) perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif
endmodule
